// File: rtl/it_ctrl_if.sv
// Pre-decoder <-> IT controller bundle: instruction/flush/restore requests in,
// ITSTATE and derived condition/block status out.
interface it_ctrl_if;
  logic       inst_valid;
  logic       stall;
  logic       it_flag;
  logic [7:0] it_status;
  logic       flush;
  logic       restore_en;
  logic [7:0] restore_val;

  logic [7:0] itstate;
  logic [3:0] it_cond;
  logic       in_it_blk;
  logic       last_in_it;
  logic [2:0] it_remain;
  logic       it_err;

  modport master (
    output inst_valid, stall, it_flag, it_status, flush, restore_en, restore_val,
    input  itstate, it_cond, in_it_blk, last_in_it, it_remain, it_err
  );

  modport slave (
    input  inst_valid, stall, it_flag, it_status, flush, restore_en, restore_val,
    output itstate, it_cond, in_it_blk, last_in_it, it_remain, it_err
  );
endinterface

// File: rtl/it_ctrl.sv
// Thumb-2 ITSTATE owner: loads on IT, advances per accepted instruction, one-cycle update latency.
// stall freezes all loads/advances; restore_en beats flush, which beats everything else.
module it_ctrl #(
  parameter logic [3:0] AL_COND         = 4'hE,
  parameter bit         CHECK_FIRSTCOND = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  it_ctrl_if.slave  bus
);

  logic [7:0] itstate_q;
  logic [7:0] itstate_d;
  logic       err_q;
  logic       err_d;
  logic       in_blk;
  logic [2:0] remain;

  // IDLE/IN_BLK is implied by the mask nibble; no separate state register.
  assign in_blk = |itstate_q[3:0];

  always_comb begin
    itstate_d = itstate_q;
    err_d     = 1'b0;
    if (bus.restore_en) begin
      itstate_d = bus.restore_val;
    end else if (bus.flush) begin
      itstate_d = 8'h00;
    end else if (bus.stall) begin
      itstate_d = itstate_q;
    end else if (bus.inst_valid) begin
      if (bus.it_flag) begin
        if (in_blk) begin
          itstate_d = 8'h00;
          err_d     = 1'b1;
        end else if (bus.it_status[3:0] == 4'h0) begin
          // mask 0 encodes a hint instruction, not an IT
          itstate_d = itstate_q;
        end else if (CHECK_FIRSTCOND && (bus.it_status[7:4] == 4'hF)) begin
          err_d = 1'b1;
        end else begin
          itstate_d = bus.it_status;
        end
      end else if (in_blk) begin
        if (itstate_q[2:0] == 3'b000) begin
          itstate_d = 8'h00;
        end else begin
          itstate_d[4:0] = {itstate_q[3:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itstate_q <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      itstate_q <= itstate_d;
      err_q     <= err_d;
    end
  end

  // Lowest set mask bit marks the terminating 1; its position gives the count left.
  always_comb begin
    remain = 3'd0;
    if (itstate_q[0])      remain = 3'd4;
    else if (itstate_q[1]) remain = 3'd3;
    else if (itstate_q[2]) remain = 3'd2;
    else if (itstate_q[3]) remain = 3'd1;
  end

  assign bus.itstate    = itstate_q;
  assign bus.in_it_blk  = in_blk;
  assign bus.it_cond    = in_blk ? itstate_q[7:4] : AL_COND;
  assign bus.last_in_it = in_blk && (itstate_q[2:0] == 3'b000);
  assign bus.it_remain  = remain;
  assign bus.it_err     = err_q;

endmodule
